issue_ctrl: RTL and testbench

Parametrised multi-issue control unit for the dual-issue MIPS datapath; the successor to the combinational per-slot decoder. Decodes an ISSUE_W-wide instruction bundle in ID and registers per-slot control into the ID/EX boundary. Splits bundles that exceed the memory-port budget or contain an intra-bundle load dependency. Inserts a one-cycle bubble on load-use hazards against EX, and honours EX backpressure and flush.

---
 rtl/mips_ctrl_pkg.sv | 28 ++
 rtl/slot_decode.sv | 53 +++++
 rtl/issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_issue_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, ALU op encodings and the per-slot control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       regwrite;
    logic       alusrc;
  } ctrl_t;

  typedef enum logic {ST_ISSUE, ST_SPLIT} issue_st_e;

endpackage

// File: rtl/slot_decode.sv
// Combinational decode of one issue slot: opcode to control bundle plus source-register usage.
module slot_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rs_o,
  output logic       uses_rt_o
);

  always_comb begin
    ctrl_o          = '0;
    ctrl_o.aluop    = ALUOP_FUNCT;
    ctrl_o.regdst   = 1'b1;
    ctrl_o.regwrite = 1'b1;
    uses_rs_o       = 1'b1;
    uses_rt_o       = 1'b0;
    case (opcode_i)
      OP_RTYPE: uses_rt_o = 1'b1;
      OP_ADDI: begin
        ctrl_o.regdst = 1'b0;
        ctrl_o.aluop  = ALUOP_ADD;
        ctrl_o.alusrc = 1'b1;
      end
      OP_LW: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.regdst  = 1'b0;
        ctrl_o.alusrc  = 1'b1;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = ALUOP_ADD;
        ctrl_o.regwrite = 1'b0;
        uses_rt_o       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.branch_eq = (opcode_i == OP_BEQ);
        ctrl_o.branch_ne = (opcode_i == OP_BNE);
        ctrl_o.aluop     = ALUOP_SUB;
        ctrl_o.regwrite  = 1'b0;
        uses_rt_o        = 1'b1;
      end
      default: begin
        // Unknown opcodes become NOPs that still occupy their slot.
        ctrl_o    = '0;
        uses_rs_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/issue_ctrl.sv
// Multi-issue ID control: decodes a bundle, forms in-order issue groups under memory-port
// and load-dependency limits, stalls on load-use against EX and registers the ID/EX controls.
module issue_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ISSUE_W   = 2,
  parameter int MEM_PORTS = 1,
  parameter int REG_AW    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [6*ISSUE_W-1:0]      id_opcode,
  input  logic [REG_AW*ISSUE_W-1:0] id_rs,
  input  logic [REG_AW*ISSUE_W-1:0] id_rt,
  output logic                      id_ready,
  input  logic                      flush,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic [ISSUE_W-1:0]        ex_slot_valid,
  output logic [ISSUE_W-1:0]        ex_branch_eq,
  output logic [ISSUE_W-1:0]        ex_branch_ne,
  output logic [ISSUE_W-1:0]        ex_memread,
  output logic [ISSUE_W-1:0]        ex_memwrite,
  output logic [ISSUE_W-1:0]        ex_regdst,
  output logic [ISSUE_W-1:0]        ex_regwrite,
  output logic [ISSUE_W-1:0]        ex_alusrc,
  output logic [2*ISSUE_W-1:0]      ex_aluop,
  output logic [REG_AW*ISSUE_W-1:0] ex_rt
);

  localparam logic [3:0] MEM_CAP = 4'(MEM_PORTS);

  logic [ISSUE_W-1:0][REG_AW-1:0] rs, rt;
  ctrl_t                          ctrl [ISSUE_W];
  logic [ISSUE_W-1:0]             use_rs, use_rt;

  issue_st_e                      state_q, state_d;
  logic [ISSUE_W-1:0]             done_q, done_d;
  logic                           ex_valid_q;
  logic [ISSUE_W-1:0]             ex_sv_q;
  ctrl_t                          ex_ctrl_q [ISSUE_W];
  logic [ISSUE_W-1:0][REG_AW-1:0] ex_rt_q;

  logic [ISSUE_W-1:0] remain, hz, grp;
  logic               stall, adv, all_done;
  logic [3:0]         mem_cnt;

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
    assign rs[g] = id_rs[REG_AW*g +: REG_AW];
    assign rt[g] = id_rt[REG_AW*g +: REG_AW];

    slot_decode u_dec (
      .opcode_i  (id_opcode[6*g +: 6]),
      .ctrl_o    (ctrl[g]),
      .uses_rs_o (use_rs[g]),
      .uses_rt_o (use_rt[g])
    );

    assign ex_branch_eq[g]     = ex_ctrl_q[g].branch_eq;
    assign ex_branch_ne[g]     = ex_ctrl_q[g].branch_ne;
    assign ex_memread[g]       = ex_ctrl_q[g].memread;
    assign ex_memwrite[g]      = ex_ctrl_q[g].memwrite;
    assign ex_regdst[g]        = ex_ctrl_q[g].regdst;
    assign ex_regwrite[g]      = ex_ctrl_q[g].regwrite;
    assign ex_alusrc[g]        = ex_ctrl_q[g].alusrc;
    assign ex_aluop[2*g +: 2]  = ex_ctrl_q[g].aluop;
  end

  always_comb begin
    logic stop, first, rdep;
    remain = (state_q == ST_ISSUE) ? '1 : ~done_q;

    hz = '0;
    for (int i = 0; i < ISSUE_W; i++)
      for (int j = 0; j < ISSUE_W; j++)
        if (ex_valid_q && ex_ctrl_q[j].memread && ex_rt_q[j] != '0 &&
            ((use_rs[i] && rs[i] == ex_rt_q[j]) || (use_rt[i] && rt[i] == ex_rt_q[j])))
          hz[i] = 1'b1;

    // Walk remaining slots oldest-first; the group ends at the first slot that cannot join.
    grp     = '0;
    stall   = 1'b0;
    stop    = 1'b0;
    first   = 1'b1;
    rdep    = 1'b0;
    mem_cnt = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (remain[i] && !stop) begin
        rdep = 1'b0;
        for (int k = 0; k < ISSUE_W; k++)
          if (k < i && grp[k] && ctrl[k].memread &&
              ((use_rs[i] && rs[i] == rt[k]) || (use_rt[i] && rt[i] == rt[k])))
            rdep = 1'b1;
        if (hz[i]) begin
          stall = first;
          stop  = 1'b1;
        end else if (!first && (rdep || ((ctrl[i].memread || ctrl[i].memwrite) && mem_cnt >= MEM_CAP))) begin
          stop = 1'b1;
        end else begin
          grp[i]  = 1'b1;
          mem_cnt = mem_cnt + {3'b000, (ctrl[i].memread | ctrl[i].memwrite)};
        end
        first = 1'b0;
      end
    end

    adv      = id_valid && ex_ready && !stall && !flush && !rst;
    done_d   = done_q | grp;
    all_done = &done_d;
    if (all_done) done_d = '0;
    state_d  = all_done ? ST_ISSUE : ST_SPLIT;
    id_ready = adv && all_done;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= ST_ISSUE;
      done_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_sv_q    <= '0;
      ex_rt_q    <= '0;
      for (int i = 0; i < ISSUE_W; i++) ex_ctrl_q[i] <= '0;
    end else if (ex_ready) begin
      if (adv) begin
        state_q    <= state_d;
        done_q     <= done_d;
        ex_valid_q <= 1'b1;
        ex_sv_q    <= grp;
        for (int i = 0; i < ISSUE_W; i++) begin
          ex_ctrl_q[i] <= grp[i] ? ctrl[i] : '0;
          ex_rt_q[i]   <= grp[i] ? rt[i] : '0;
        end
      end else begin
        // Bubble or idle: drop the valid, keep done so a stalled bundle resumes in place.
        ex_valid_q <= 1'b0;
        ex_sv_q    <= '0;
      end
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_slot_valid = ex_sv_q;
  assign ex_rt         = ex_rt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl (ISSUE_W=2, MEM_PORTS=1): expected groups queued at issue,
// popped by a monitor whenever EX accepts a valid group.
module tb_issue_ctrl;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ILL  = 6'b111111;

  // {slot_valid, beq, bne, memread, memwrite, regdst, regwrite, alusrc, aluop, rt1, rt0}
  localparam logic [29:0] E_PAIR = {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 4'b0010, 5'd4, 5'd2};
  localparam logic [29:0] E_LW4  = {2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 4'b0000, 5'd0, 5'd4};
  localparam logic [29:0] E_SW5  = {2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 4'b0000, 5'd5, 5'd0};

  logic        clk = 1'b0;
  logic        rst, id_valid, flush, ex_ready;
  logic [11:0] id_opcode;
  logic [9:0]  id_rs, id_rt;
  logic        id_ready, ex_valid;
  logic [1:0]  ex_slot_valid, ex_branch_eq, ex_branch_ne, ex_memread, ex_memwrite;
  logic [1:0]  ex_regdst, ex_regwrite, ex_alusrc;
  logic [3:0]  ex_aluop;
  logic [9:0]  ex_rt;

  issue_ctrl #(.ISSUE_W(2), .MEM_PORTS(1), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_slot_valid(ex_slot_valid), .ex_branch_eq(ex_branch_eq),
    .ex_branch_ne(ex_branch_ne), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regdst(ex_regdst), .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc),
    .ex_aluop(ex_aluop), .ex_rt(ex_rt)
  );

  always #5 clk = ~clk;

  wire [29:0] grp_out = {ex_slot_valid, ex_branch_eq, ex_branch_ne, ex_memread, ex_memwrite,
                         ex_regdst, ex_regwrite, ex_alusrc, ex_aluop, ex_rt};
  wire [30:0] all_out = {ex_valid, grp_out};

  typedef struct {
    string       nm;
    logic [29:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [29:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic bun(input logic [5:0] o1, input logic [5:0] o0, input logic [4:0] s1,
                     input logic [4:0] s0, input logic [4:0] t1, input logic [4:0] t0);
    id_valid  = 1'b1;
    id_opcode = {o1, o0};
    id_rs     = {s1, s0};
    id_rt     = {t1, t0};
  endtask

  // One cycle: check id_ready (and optionally ex_valid) mid-cycle, then step past the edge.
  task automatic tick(input string nm, input logic rdy, input int ev);
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(id_ready), 32'(rdy));
    if (ev >= 0) chk({nm, "_ev"}, 32'(ex_valid), 32'(ev[0]));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ex_valid && ex_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_group act=%0h exp=none", grp_out);
      end else begin
        e = q.pop_front();
        chk(e.nm, 32'(grp_out), 32'(e.v));
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_opcode = '0; id_rs = '0; id_rt = '0;
    repeat (2) @(posedge clk);
    #1;
    bun(ADDI, ADD, 5'd3, 5'd1, 5'd4, 5'd2);
    @(negedge clk);
    chk("rst_rdy", 32'(id_ready), 32'd0);
    chk("rst_out", 32'(all_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Independent pair issues in one cycle
    push("t1", E_PAIR); tick("t1", 1'b1, 0);

    // Two memory ops split across two cycles
    bun(SW, LW, 5'd2, 5'd1, 5'd5, 5'd4);
    push("t2a", E_LW4); tick("t2a", 1'b0, 1);
    push("t2b", E_SW5); tick("t2b", 1'b1, 1);

    // Load-use against EX: one bubble
    bun(ADD, LW, 5'd2, 5'd1, 5'd9, 5'd8);
    push("t3a", {2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 4'b1000, 5'd9, 5'd8});
    tick("t3a", 1'b1, 1);
    bun(ADDI, ADD, 5'd7, 5'd8, 5'd0, 5'd6);
    tick("t3stall", 1'b0, 1);
    push("t3b", {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 4'b0010, 5'd0, 5'd6});
    tick("t3b", 1'b1, 0);

    // Load to $0 never creates a hazard
    bun(ADD, LW, 5'd2, 5'd1, 5'd9, 5'd0);
    push("t3za", {2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 4'b1000, 5'd9, 5'd0});
    tick("t3za", 1'b1, 1);
    bun(ADDI, ADD, 5'd7, 5'd0, 5'd0, 5'd6);
    push("t3zb", {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 4'b0010, 5'd0, 5'd6});
    tick("t3zb", 1'b1, 1);

    // Intra-bundle load dependency: split, then load-use bubble
    bun(BEQ, LW, 5'd3, 5'd1, 5'd2, 5'd3);
    push("t4a", {2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 4'b0000, 5'd0, 5'd3});
    tick("t4a", 1'b0, 1);
    tick("t4stall", 1'b0, 1);
    push("t4b", {2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0100, 5'd2, 5'd0});
    tick("t4b", 1'b1, 0);

    // Illegal opcode in slot 1 is an issued NOP
    bun(ILL, ADD, 5'd3, 5'd1, 5'd4, 5'd2);
    push("t5", {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 4'b0010, 5'd4, 5'd2});
    tick("t5", 1'b1, 1);

    // Backpressure mid-split holds outputs and progress
    bun(SW, LW, 5'd2, 5'd1, 5'd5, 5'd4);
    push("t6a", E_LW4); tick("t6a", 1'b0, 1);
    ex_ready = 1'b0;
    repeat (3) begin
      tick("t6hold", 1'b0, 1);
      chk("t6hold_out", 32'(grp_out), 32'(E_LW4));
    end
    ex_ready = 1'b1;
    push("t6b", E_SW5); tick("t6b", 1'b1, 1);

    // Flush mid-split: next bundle restarts at slot 0
    bun(SW, LW, 5'd2, 5'd1, 5'd5, 5'd4);
    push("t7a", E_LW4); tick("t7a", 1'b0, 1);
    flush = 1'b1;
    tick("t7flush", 1'b0, 1);
    flush = 1'b0;
    bun(ADDI, ADD, 5'd3, 5'd1, 5'd4, 5'd2);
    push("t7b", E_PAIR); tick("t7b", 1'b1, 0);

    // Reset mid-split clears everything
    bun(SW, LW, 5'd2, 5'd1, 5'd5, 5'd4);
    push("t8a", E_LW4); tick("t8a", 1'b0, 1);
    rst = 1'b1;
    tick("t8rst", 1'b0, 1);
    chk("t8rst_out", 32'(all_out), 32'd0);
    rst = 1'b0;
    bun(ADDI, ADD, 5'd3, 5'd1, 5'd4, 5'd2);
    push("t8b", E_PAIR); tick("t8b", 1'b1, 0);

    id_valid = 1'b0;
    tick("idle", 1'b0, 1);
    tick("idle2", 1'b0, 0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
